fetch_queue: RTL and testbench

- Parametrised successor to the single-entry fetch stage.
- Decouples instruction-memory latency from the pipeline with a DEPTH-entry {pc, instr} prefetch FIFO.
- Redirect-safe: keeps at most one request outstanding, discards in-flight responses after a PC change, and feeds decode through the existing clk_en/stall/flush protocol.
- Sits between instruction memory and decode.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_queue.sv | 200 ++++++++++++++++++++
 tb/tb_fetch_queue.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared fetch-queue state encoding and constants
package fetch_queue_pkg;

  // FETCH issues requests normally; DISCARD waits out a response made stale by a redirect.
  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry prefetch FIFO with push/pop/clear and occupancy count
module fetch_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Pointer and occupancy update; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; the head is read combinationally, so a same-cycle push never disturbs it.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetching fetch stage; define FETCH_PERF_CNT_EN for starve/discard counters
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [XLEN-1:0] instr_addr,
  output logic            instr_req,
  input  logic            instr_ack,
  input  logic [XLEN-1:0] instr_mem,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr_send,
  output logic            clk_en,
  input  logic            stall,
  input  logic            flush,
  input  logic            writeback_change_pc,
  input  logic [XLEN-1:0] writeback_next_pc,
  input  logic            alu_change_pc,
  input  logic [XLEN-1:0] alu_next_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     starve_count,
  output logic [31:0]     discard_count
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] pending_q, pending_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            clk_en_q, clk_en_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            ack_ok;
  logic            bypass;
  logic            fifo_push;
  logic            fifo_pop;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   count_next;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign redirect   = writeback_change_pc | alu_change_pc;
  assign target     = writeback_change_pc ? writeback_next_pc : alu_next_pc;
  assign ack_ok     = req_q & instr_ack;
  assign bypass     = (state_q == FETCH) & ack_ok & ~redirect & ~stall & ~flush & fifo_empty;
  assign fifo_pop   = ~redirect & ~stall & ~flush & ~fifo_empty;
  assign fifo_push  = (state_q == FETCH) & ack_ok & ~redirect & ~bypass & (~fifo_full | fifo_pop);
  assign count_next = redirect ? '0 : fifo_count + CW'(fifo_push) - CW'(fifo_pop);
  assign push_entry = '{pc: addr_q, instr: instr_mem};

  fetch_fifo #(
    .W     (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (redirect),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (push_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Request/address control: hold a request until acked, redirect immediately or via DISCARD.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pending_d = pending_q;
    req_d     = req_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          if (req_q && !instr_ack) begin
            state_d   = DISCARD;
            pending_d = target;
          end else begin
            addr_d = target;
            req_d  = 1'b1;
          end
        end else if (req_q && !instr_ack) begin
          req_d = 1'b1;
        end else begin
          if (ack_ok) addr_d = addr_q + XLEN'(INSTR_BYTES);
          req_d = (count_next < CW'(DEPTH));
        end
      end
      DISCARD: begin
        if (instr_ack) begin
          addr_d  = redirect ? target : pending_q;
          state_d = FETCH;
          req_d   = 1'b1;
        end else if (redirect) begin
          pending_d = target;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Decode-facing output register: redirect clears, stall holds, otherwise pop or bypass.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    clk_en_d = clk_en_q;
    if (redirect) begin
      clk_en_d = 1'b0;
    end else if (!stall) begin
      if (flush) begin
        clk_en_d = 1'b0;
      end else if (!fifo_empty) begin
        pc_d     = head.pc;
        instr_d  = head.instr;
        clk_en_d = 1'b1;
      end else if (bypass) begin
        pc_d     = addr_q;
        instr_d  = instr_mem;
        clk_en_d = 1'b1;
      end else begin
        clk_en_d = 1'b0;
      end
    end
  end

  // State, request and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= FETCH;
      addr_q    <= PC_RESET;
      pending_q <= '0;
      req_q     <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      clk_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      clk_en_q  <= clk_en_d;
    end
  end

  assign instr_addr = addr_q;
  assign instr_req  = req_q;
  assign pc         = pc_q;
  assign instr_send = instr_q;
  assign clk_en     = clk_en_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] starve_q, starve_d;
  logic [31:0] discard_q, discard_d;

  // Saturating counters for decode starvation and dropped stale responses.
  always_comb begin
    starve_d  = starve_q;
    discard_d = discard_q;
    if (!stall && !redirect && fifo_empty && !bypass && (starve_q != '1))
      starve_d = starve_q + 32'd1;
    if (ack_ok && (redirect || (state_q == DISCARD)) && (discard_q != '1))
      discard_d = discard_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_q  <= '0;
      discard_q <= '0;
    end else begin
      starve_q  <= starve_d;
      discard_q <= discard_d;
    end
  end

  assign starve_count  = starve_q;
  assign discard_count = discard_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic        clk;
  logic        rstn;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic        instr_ack;
  logic [31:0] instr_mem;
  logic [31:0] pc;
  logic [31:0] instr_send;
  logic        clk_en;
  logic        stall;
  logic        flush;
  logic        writeback_change_pc;
  logic [31:0] writeback_next_pc;
  logic        alu_change_pc;
  logic [31:0] alu_next_pc;

  logic        rstn_w;
  logic [31:0] instr_addr_w;
  logic        instr_req_w;
  logic        instr_ack_w;
  logic [31:0] instr_mem_w;
  logic [31:0] pc_w;
  logic [31:0] instr_send_w;
  logic        clk_en_w;

  logic        ack_drv;
  logic        late_ack;
  logic [31:0] mem_data;
  int          mem_lat;
  int          ack_budget;
  int          wait_cnt;

  int          checks;
  int          failures;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] starve_count, discard_count, starve_count_w, discard_count_w;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  fetch_queue dut (
    .clk                 (clk),
    .rstn                (rstn),
    .instr_addr          (instr_addr),
    .instr_req           (instr_req),
    .instr_ack           (instr_ack),
    .instr_mem           (instr_mem),
    .pc                  (pc),
    .instr_send          (instr_send),
    .clk_en              (clk_en),
    .stall               (stall),
    .flush               (flush),
    .writeback_change_pc (writeback_change_pc),
    .writeback_next_pc   (writeback_next_pc),
    .alu_change_pc       (alu_change_pc),
    .alu_next_pc         (alu_next_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .starve_count        (starve_count),
    .discard_count       (discard_count)
`endif
  );

  fetch_queue #(.PC_RESET(32'hFFFF_FFFC)) dut_w (
    .clk                 (clk),
    .rstn                (rstn_w),
    .instr_addr          (instr_addr_w),
    .instr_req           (instr_req_w),
    .instr_ack           (instr_ack_w),
    .instr_mem           (instr_mem_w),
    .pc                  (pc_w),
    .instr_send          (instr_send_w),
    .clk_en              (clk_en_w),
    .stall               (1'b0),
    .flush               (1'b0),
    .writeback_change_pc (1'b0),
    .writeback_next_pc   (32'h0),
    .alu_change_pc       (1'b0),
    .alu_next_pc         (32'h0)
`ifdef FETCH_PERF_CNT_EN
    ,
    .starve_count        (starve_count_w),
    .discard_count       (discard_count_w)
`endif
  );

  assign instr_ack   = ack_drv | late_ack;
  assign instr_mem   = mem_data;
  assign instr_ack_w = instr_req_w;
  assign instr_mem_w = mem_word(instr_addr_w);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction memory: acks after mem_lat idle cycles, up to ack_budget responses.
  initial begin
    ack_drv  = 1'b0;
    mem_data = '0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (ack_drv) wait_cnt = 0;
      if (instr_req && rstn && ack_budget > 0) begin
        if (wait_cnt >= mem_lat) begin
          ack_drv    = 1'b1;
          mem_data   = mem_word(instr_addr);
          ack_budget = ack_budget - 1;
        end else begin
          ack_drv  = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        ack_drv  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic do_reset(input int lat, input int budget);
    rstn                = 1'b0;
    stall               = 1'b0;
    flush               = 1'b0;
    writeback_change_pc = 1'b0;
    writeback_next_pc   = '0;
    alu_change_pc       = 1'b0;
    alu_next_pc         = '0;
    late_ack            = 1'b0;
    mem_lat             = lat;
    ack_budget          = budget;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_req_addr(input logic [31:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (instr_req && instr_addr == a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_clk_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (clk_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    rstn_w = 1'b0;
    late_ack = 1'b0;
    mem_lat = 0;
    ack_budget = 0;
    repeat (3) @(negedge clk);
    checks++; if (instr_req !== 1'b0)   begin failures++; $display("FAIL reset_req: got %b want 0", instr_req); end
    checks++; if (instr_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", instr_addr); end
    checks++; if (pc !== 32'h0)         begin failures++; $display("FAIL reset_pc: got %h want 0", pc); end
    checks++; if (instr_send !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", instr_send); end
    checks++; if (clk_en !== 1'b0)      begin failures++; $display("FAIL reset_clk_en: got %b want 0", clk_en); end
    checks++; if (instr_addr_w !== 32'hFFFF_FFFC) begin failures++; $display("FAIL reset_addr_w: got %h want fffffffc", instr_addr_w); end
  endtask

  task automatic test_zero_wait;
    do_reset(0, 1000000);
    @(negedge clk);
    checks++; if (instr_req !== 1'b1 || instr_addr !== 32'h0) begin failures++; $display("FAIL zw_first_req: got req=%b addr=%h want 1/0", instr_req, instr_addr); end
    checks++; if (clk_en !== 1'b0) begin failures++; $display("FAIL zw_no_early_clk_en: got %b want 0", clk_en); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (clk_en !== 1'b1 || pc !== 32'(4*k) || instr_send !== mem_word(32'(4*k))) begin
        failures++;
        $display("FAIL zw_stream[%0d]: got en=%b pc=%h instr=%h want 1/%h/%h", k, clk_en, pc, instr_send, 32'(4*k), mem_word(32'(4*k)));
      end
    end
  endtask

  task automatic test_stall_fill;
    do_reset(0, 1000000);
    repeat (2) @(negedge clk);
    checks++; if (clk_en !== 1'b1 || pc !== 32'h0) begin failures++; $display("FAIL sf_pre: got en=%b pc=%h want 1/0", clk_en, pc); end
    stall = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (clk_en !== 1'b1 || pc !== 32'h0 || instr_send !== mem_word(32'h0)) begin
        failures++;
        $display("FAIL sf_hold[%0d]: got en=%b pc=%h instr=%h want 1/0/%h", k, clk_en, pc, instr_send, mem_word(32'h0));
      end
    end
    checks++; if (instr_req !== 1'b0)    begin failures++; $display("FAIL sf_full_req: got %b want 0", instr_req); end
    checks++; if (instr_addr !== 32'h14) begin failures++; $display("FAIL sf_full_addr: got %h want 14", instr_addr); end
    stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (instr_req !== 1'b1) begin failures++; $display("FAIL sf_req_reassert: got %b want 1", instr_req); end
      end
      checks++;
      if (clk_en !== 1'b1 || pc !== 32'(4 + 4*k) || instr_send !== mem_word(32'(4 + 4*k))) begin
        failures++;
        $display("FAIL sf_drain[%0d]: got en=%b pc=%h instr=%h want 1/%h/%h", k, clk_en, pc, instr_send, 32'(4 + 4*k), mem_word(32'(4 + 4*k)));
      end
    end
  endtask

  task automatic test_redirect;
    bit ok;
    do_reset(3, 1000000);
    wait_req_addr(32'h8, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rd_wait_req8: got timeout want request on 8"); end
    @(negedge clk);
    alu_change_pc = 1'b1;
    alu_next_pc   = 32'h100;
    @(negedge clk);
    alu_change_pc = 1'b0;
    checks++; if (clk_en !== 1'b0) begin failures++; $display("FAIL rd_clk_en_clear: got %b want 0", clk_en); end
    checks++; if (instr_req !== 1'b1 || instr_addr !== 32'h8) begin failures++; $display("FAIL rd_hold_old: got req=%b addr=%h want 1/8", instr_req, instr_addr); end
    wait_req_addr(32'h100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rd_addr_100: got addr=%h want 100", instr_addr); end
    wait_clk_en(ok);
    checks++;
    if (!ok || pc !== 32'h100 || instr_send !== mem_word(32'h100)) begin
      failures++;
      $display("FAIL rd_first_pc: got ok=%b pc=%h instr=%h want 100/%h", ok, pc, instr_send, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_priority;
    bit ok;
    writeback_change_pc = 1'b1;
    writeback_next_pc   = 32'h200;
    alu_change_pc       = 1'b1;
    alu_next_pc         = 32'h300;
    @(negedge clk);
    writeback_change_pc = 1'b0;
    alu_change_pc       = 1'b0;
    checks++; if (clk_en !== 1'b0) begin failures++; $display("FAIL pr_clk_en_clear: got %b want 0", clk_en); end
    wait_req_addr(32'h200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL pr_addr_200: got addr=%h want 200", instr_addr); end
    wait_clk_en(ok);
    checks++;
    if (!ok || pc !== 32'h200) begin failures++; $display("FAIL pr_first_pc: got ok=%b pc=%h want 200", ok, pc); end
    alu_change_pc = 1'b1;
    alu_next_pc   = 32'h300;
    @(negedge clk);
    alu_next_pc   = 32'h400;
    @(negedge clk);
    alu_change_pc = 1'b0;
    wait_req_addr(32'h400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL pr_addr_400: got addr=%h want 400", instr_addr); end
    wait_clk_en(ok);
    checks++;
    if (!ok || pc !== 32'h400 || instr_send !== mem_word(32'h400)) begin
      failures++;
      $display("FAIL pr_latest_pc: got ok=%b pc=%h instr=%h want 400/%h", ok, pc, instr_send, mem_word(32'h400));
    end
  endtask

  task automatic test_flush;
    do_reset(0, 3);
    repeat (2) @(negedge clk);
    checks++; if (clk_en !== 1'b1 || pc !== 32'h0) begin failures++; $display("FAIL fl_pre: got en=%b pc=%h want 1/0", clk_en, pc); end
    stall = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (instr_req !== 1'b1 || instr_addr !== 32'hC) begin failures++; $display("FAIL fl_wait_req: got req=%b addr=%h want 1/c", instr_req, instr_addr); end
    stall = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (clk_en !== 1'b0) begin failures++; $display("FAIL fl_gap: got %b want 0", clk_en); end
    @(negedge clk);
    checks++; if (clk_en !== 1'b1 || pc !== 32'h4) begin failures++; $display("FAIL fl_entry0: got en=%b pc=%h want 1/4", clk_en, pc); end
    @(negedge clk);
    checks++; if (clk_en !== 1'b1 || pc !== 32'h8 || instr_send !== mem_word(32'h8)) begin failures++; $display("FAIL fl_entry1: got en=%b pc=%h want 1/8", clk_en, pc); end
    @(negedge clk);
    checks++; if (clk_en !== 1'b0) begin failures++; $display("FAIL fl_drained: got %b want 0", clk_en); end
  endtask

  task automatic test_wrap;
    bit ok;
    @(negedge clk);
    rstn_w = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (clk_en_w) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || pc_w !== 32'hFFFF_FFFC || instr_send_w !== mem_word(32'hFFFF_FFFC)) begin
      failures++;
      $display("FAIL wr_first: got ok=%b pc=%h instr=%h want fffffffc/%h", ok, pc_w, instr_send_w, mem_word(32'hFFFF_FFFC));
    end
    @(negedge clk);
    checks++; if (clk_en_w !== 1'b1 || pc_w !== 32'h0) begin failures++; $display("FAIL wr_wrap0: got en=%b pc=%h want 1/0", clk_en_w, pc_w); end
    @(negedge clk);
    checks++; if (clk_en_w !== 1'b1 || pc_w !== 32'h4) begin failures++; $display("FAIL wr_wrap4: got en=%b pc=%h want 1/4", clk_en_w, pc_w); end
    @(posedge clk);
    #2 rstn_w = 1'b0;
    #1;
    checks++;
    if (instr_req_w !== 1'b0 || instr_addr_w !== 32'hFFFF_FFFC || clk_en_w !== 1'b0) begin
      failures++;
      $display("FAIL wr_async_reset: got req=%b addr=%h en=%b want 0/fffffffc/0", instr_req_w, instr_addr_w, clk_en_w);
    end
  endtask

  task automatic test_reset_mid_request;
    bit ok;
    do_reset(0, 1000000);
    repeat (3) @(negedge clk);
    checks++; if (pc !== 32'h4 || instr_req !== 1'b1) begin failures++; $display("FAIL rm_pre: got pc=%h req=%b want 4/1", pc, instr_req); end
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (instr_req !== 1'b0 || instr_addr !== 32'h0 || clk_en !== 1'b0 || pc !== 32'h0 || instr_send !== 32'h0) begin
      failures++;
      $display("FAIL rm_async: got req=%b addr=%h en=%b pc=%h instr=%h want 0/0/0/0/0", instr_req, instr_addr, clk_en, pc, instr_send);
    end
    @(negedge clk);
    rstn = 1'b1;
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    checks++;
    if (clk_en !== 1'b0 || instr_addr !== 32'h0 || instr_req !== 1'b1) begin
      failures++;
      $display("FAIL rm_late_ack: got en=%b addr=%h req=%b want 0/0/1", clk_en, instr_addr, instr_req);
    end
    wait_clk_en(ok);
    checks++;
    if (!ok || pc !== 32'h0 || instr_send !== mem_word(32'h0)) begin
      failures++;
      $display("FAIL rm_restart: got ok=%b pc=%h instr=%h want 0/%h", ok, pc, instr_send, mem_word(32'h0));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_zero_wait();
    test_stall_fill();
    test_redirect();
    test_redirect_priority();
    test_flush();
    test_wrap();
    test_reset_mid_request();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
